// File: rtl/vip_dscale_box.sv
// vip_dscale_box: 2-D downscaler (factors 1/2/4/8 per axis) with decimate or
// box-average mode. A per-column line buffer carries partial vertical sums
// (average mode) or the held top-left pixel (decimate mode) between rows.
//
// Ports:
//   pclk      - pixel clock, sole clock
//   rst_n     - asynchronous active-low reset
//   h_shift   - horizontal factor = 2^h_shift (latched at frame start)
//   v_shift   - vertical factor   = 2^v_shift (latched at frame start)
//   avg_en    - 1 = box average, 0 = decimate (latched at frame start)
//   in_href   - input line valid, one pixel per cycle while high
//   in_vsync  - input frame sync, high = blanking, falling edge = frame start
//   in_data   - input pixel
//   out_href  - output line envelope (in_href delayed, final rows only)
//   out_vsync - in_vsync delayed one cycle
//   out_valid - one-cycle strobe per output pixel
//   out_data  - output pixel, 0 when out_valid is low
module vip_dscale_box #(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic [1:0]      h_shift,
    input  logic [1:0]      v_shift,
    input  logic            avg_en,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_data,
    output logic            out_href,
    output logic            out_vsync,
    output logic            out_valid,
    output logic [BITS-1:0] out_data
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = BITS + 3;
    localparam int MW = BITS + 6;
    localparam int AW = BITS + 7;
    // A vertical factor taller than the frame could never complete a block.
    localparam logic [1:0] VMAX = (HEIGHT >= 8) ? 2'd3 :
                                  (HEIGHT >= 4) ? 2'd2 :
                                  (HEIGHT >= 2) ? 2'd1 : 2'd0;

    logic            prev_vsync, prev_href, cfg_ok;
    logic [1:0]      h_lat, v_lat;
    logic            avg_lat;
    logic            frame_start, load;
    logic [1:0]      h_eff, v_eff, v_req;
    logic            avg_eff;
    logic            href_rise, href_fall;
    logic [2:0]      hcnt, hpos, hmask, vcnt, vrow, vmask, hv;
    logic [CW-1:0]   col, colpos, raddr;
    logic [SW-1:0]   hsum, hsum_cur;
    logic [BITS-1:0] hold, dec_pix, result;
    logic            blk_start, blk_done, row_first, row_last;
    logic [MW-1:0]   mem [WIDTH];
    logic [MW-1:0]   rd_q, wdata;
    logic            we;
    logic [AW-1:0]   acc, rnd, avg_full;

    always_comb begin
        frame_start = prev_vsync & ~in_vsync;
        load        = frame_start | ~cfg_ok;
        v_req       = (v_shift > VMAX) ? VMAX : v_shift;
        // Forward the new configuration on the latch cycle so a line starting
        // exactly at frame start already uses it.
        h_eff       = load ? h_shift : h_lat;
        v_eff       = load ? v_req   : v_lat;
        avg_eff     = load ? avg_en  : avg_lat;

        href_rise   = in_href & ~prev_href;
        href_fall   = ~in_href & prev_href;
        hmask       = 3'((4'd1 << h_eff) - 4'd1);
        vmask       = 3'((4'd1 << v_eff) - 4'd1);
        hpos        = href_rise   ? '0 : hcnt;
        vrow        = frame_start ? '0 : vcnt;
        colpos      = href_rise   ? '0 : col;

        blk_start   = (hpos & hmask) == 3'd0;
        blk_done    = in_href & ((hpos & hmask) == hmask);
        row_first   = vrow == 3'd0;
        row_last    = vrow == vmask;

        hsum_cur    = blk_start ? SW'(in_data) : hsum + SW'(in_data);
        dec_pix     = blk_start ? in_data : hold;

        // Read address targets the column of the next cycle's pixel, so the
        // registered read data is ready when that pixel's block completes
        // (needed for single-pixel-wide blocks).
        if (!in_href)
            raddr = '0;
        else if (blk_done)
            raddr = colpos + CW'(1);
        else
            raddr = colpos;

        acc      = (v_eff == 2'd0) ? AW'(hsum_cur) : AW'(rd_q) + AW'(hsum_cur);
        hv       = {1'b0, h_eff} + {1'b0, v_eff};
        rnd      = (hv == 3'd0) ? '0 : (AW'(1) << (hv - 3'd1));
        avg_full = (acc + rnd) >> hv;

        if (avg_eff)
            result = avg_full[BITS-1:0];
        else if (v_eff == 2'd0)
            result = dec_pix;
        else
            result = rd_q[BITS-1:0];

        if (avg_eff) begin
            we    = blk_done & ~row_last;
            wdata = row_first ? MW'(hsum_cur) : rd_q + MW'(hsum_cur);
        end else begin
            we    = blk_done & row_first & ~row_last;
            wdata = MW'(dec_pix);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            prev_vsync <= 1'b0;
            prev_href  <= 1'b0;
            cfg_ok     <= 1'b0;
            h_lat      <= '0;
            v_lat      <= '0;
            avg_lat    <= 1'b0;
            hcnt       <= '0;
            vcnt       <= '0;
            col        <= '0;
            hsum       <= '0;
            hold       <= '0;
            out_href   <= 1'b0;
            out_vsync  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            prev_vsync <= in_vsync;
            prev_href  <= in_href;
            cfg_ok     <= 1'b1;
            if (load) begin
                h_lat   <= h_eff;
                v_lat   <= v_eff;
                avg_lat <= avg_eff;
            end
            if (in_href) begin
                hcnt <= hpos + 3'd1;
                hsum <= hsum_cur;
                hold <= dec_pix;
                col  <= blk_done ? colpos + CW'(1) : colpos;
            end
            if (frame_start)
                vcnt <= '0;
            else if (href_fall)
                vcnt <= (vcnt + 3'd1) & vmask;
            out_vsync <= in_vsync;
            out_href  <= in_href & row_last;
            out_valid <= blk_done & row_last;
            out_data  <= (blk_done & row_last) ? result : '0;
        end
    end

    // Line buffer: contents need no reset, row 0 of every block rewrites them.
    always_ff @(posedge pclk) begin
        if (we)
            mem[colpos] <= wdata;
        rd_q <= mem[raddr];
    end

endmodule

// File: tb/tb_vip_dscale_box.sv
// Directed testbench for vip_dscale_box (BITS=8, WIDTH=16).
module tb_vip_dscale_box;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic [1:0] h_shift, v_shift;
    logic       avg_en, in_href, in_vsync;
    logic [7:0] in_data;
    logic       out_href, out_vsync, out_valid;
    logic [7:0] out_data;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] got [$];
    int         gidx [$];
    logic       href_seen;
    logic [7:0] pix [16];
    int         ev [8];
    int         ei [8];

    vip_dscale_box #(.BITS(8), .WIDTH(16), .HEIGHT(16)) dut (
        .pclk(pclk), .rst_n(rst_n), .h_shift(h_shift), .v_shift(v_shift),
        .avg_en(avg_en), .in_href(in_href), .in_vsync(in_vsync), .in_data(in_data),
        .out_href(out_href), .out_vsync(out_vsync), .out_valid(out_valid),
        .out_data(out_data)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One pixel cycle; afterwards the outputs reflect this cycle's input.
    task automatic cyc(input logic href, input logic [7:0] d, input int idx);
        @(negedge pclk);
        in_href = href;
        in_data = d;
        @(posedge pclk);
        #1;
        if (out_href) href_seen = 1'b1;
        if (out_valid) begin
            got.push_back(out_data);
            gidx.push_back(idx);
            chk("valid_in_env", 32'(out_href), 32'd1);
        end else begin
            chk("data_zero_idle", 32'(out_data), 32'd0);
        end
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, pix[i], i);
        cyc(1'b0, 8'd0, -1);
    endtask

    task automatic frame(input bit idle);
        in_vsync = 1'b1;
        cyc(1'b0, 8'd0, -1);
        chk("vsync_hi", 32'(out_vsync), 32'd1);
        cyc(1'b0, 8'd0, -1);
        in_vsync = 1'b0;
        if (idle) begin
            cyc(1'b0, 8'd0, -1);
            chk("vsync_lo", 32'(out_vsync), 32'd0);
        end
    endtask

    task automatic check_out(input string tag, input int n);
        chk({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, (i < got.size())  ? 32'(got[i])  : 32'hffff_ffff, 32'(ev[i]));
            chk({tag, "_when"}, (i < gidx.size()) ? 32'(gidx[i]) : 32'h7fff_ffff, 32'(ei[i]));
        end
        got.delete();
        gidx.delete();
    endtask

    initial begin
        rst_n = 1'b0; h_shift = 2'd0; v_shift = 2'd0; avg_en = 1'b1;
        in_href = 1'b0; in_vsync = 1'b1; in_data = 8'hff; href_seen = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_href",  32'(out_href),  32'd0);
        chk("rst_vsync", 32'(out_vsync), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        @(negedge pclk);
        rst_n = 1'b1;

        // Bypass: h=v=0, first line rises on the frame-start cycle.
        frame(1'b0);
        pix[0] = 10; pix[1] = 20; pix[2] = 30; pix[3] = 40;
        send_line(4);
        send_line(4);
        ev = '{10, 20, 30, 40, 10, 20, 30, 40};
        ei = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_out("bypass", 8);

        // 2x2 average.
        h_shift = 2'd1; v_shift = 2'd1; avg_en = 1'b1;
        frame(1'b1);
        href_seen = 1'b0;
        send_line(4);
        chk("avg_row0_valid", 32'(got.size()), 32'd0);
        chk("avg_row0_href", 32'(href_seen), 32'd0);
        pix[0] = 50; pix[1] = 60; pix[2] = 70; pix[3] = 80;
        send_line(4);
        ev = '{35, 55, 0, 0, 0, 0, 0, 0};
        ei = '{1, 3, 0, 0, 0, 0, 0, 0};
        check_out("avg2x2", 2);

        // 4x4 decimate over an 8x4 frame, data = 16*row + col.
        h_shift = 2'd2; v_shift = 2'd2; avg_en = 1'b0;
        frame(1'b1);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) pix[c] = 8'(16 * r + c);
            send_line(8);
            if (r == 2) chk("dec_rows012", 32'(got.size()), 32'd0);
        end
        ev = '{0, 4, 0, 0, 0, 0, 0, 0};
        ei = '{3, 7, 0, 0, 0, 0, 0, 0};
        check_out("dec4x4", 2);

        // Rounding and discarded partial block.
        h_shift = 2'd2; v_shift = 2'd0; avg_en = 1'b1;
        frame(1'b1);
        pix[0] = 1; pix[1] = 2; pix[2] = 2; pix[3] = 2; pix[4] = 9; pix[5] = 9;
        send_line(6);
        ev = '{2, 0, 0, 0, 0, 0, 0, 0};
        ei = '{3, 0, 0, 0, 0, 0, 0, 0};
        check_out("round", 1);

        // Config latch: factor change mid-frame waits for the next frame.
        h_shift = 2'd1; v_shift = 2'd0; avg_en = 1'b1;
        frame(1'b1);
        pix[0] = 10; pix[1] = 20; pix[2] = 30; pix[3] = 40;
        send_line(4);
        h_shift = 2'd0;
        send_line(4);
        ev = '{15, 35, 15, 35, 0, 0, 0, 0};
        ei = '{1, 3, 1, 3, 0, 0, 0, 0};
        check_out("cfg_hold", 4);
        frame(1'b1);
        send_line(4);
        ev = '{10, 20, 30, 40, 0, 0, 0, 0};
        ei = '{0, 1, 2, 3, 0, 0, 0, 0};
        check_out("cfg_next", 4);

        // Reset mid-line during row 1 of a 2x2 average frame.
        h_shift = 2'd1; v_shift = 2'd1; avg_en = 1'b1;
        frame(1'b1);
        send_line(4);
        cyc(1'b1, 8'd50, 0);
        cyc(1'b1, 8'd60, 1);
        ev = '{35, 0, 0, 0, 0, 0, 0, 0};
        ei = '{1, 0, 0, 0, 0, 0, 0, 0};
        check_out("pre_rst", 1);
        rst_n = 1'b0;
        in_href = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  32'(out_data),  32'd0);
        chk("mid_rst_href",  32'(out_href),  32'd0);
        @(posedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        frame(1'b1);
        for (int i = 0; i < 4; i++) pix[i] = 100;
        send_line(4);
        for (int i = 0; i < 4; i++) pix[i] = 200;
        send_line(4);
        ev = '{150, 150, 0, 0, 0, 0, 0, 0};
        ei = '{1, 3, 0, 0, 0, 0, 0, 0};
        check_out("post_rst", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
